// File: rtl/sm_extreme_tracker.sv
// Streaming max/min tracker for sign-magnitude samples over a valid/ready frame.
// Reports frame max, min, index of the first max and a saturating beat count.

module sm_ge #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_ge
);
  logic         w_sa;
  logic         w_sb;
  logic [N-2:0] w_ma;
  logic [N-2:0] w_mb;

  assign w_sa = i_a[N-1];
  assign w_sb = i_b[N-1];
  assign w_ma = i_a[N-2:0];
  assign w_mb = i_b[N-2:0];

  // NOTE: o_ge gets a default before the branches so no path leaves it unassigned (no latch).
  always_comb begin
    o_ge = 1'b0;
    case ({w_sa, w_sb})
      2'b00:   o_ge = (w_ma >= w_mb);
      2'b01:   o_ge = 1'b1;
      2'b10:   o_ge = 1'b0;
      default: o_ge = (w_ma <= w_mb);  // both negative: larger magnitude is smaller
    endcase
  end
endmodule

module sm_extreme_tracker #(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [N-1:0]     i_data,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [N-1:0]     o_max,
  output logic [N-1:0]     o_min,
  output logic [CNT_W-1:0] o_max_idx,
  output logic [CNT_W-1:0] o_count,
  output logic             o_ovf
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  state_t           r_state;
  logic [1:0]       r_rst_sync;
  logic             r_ready;
  logic             r_valid;
  logic [N-1:0]     r_max;
  logic [N-1:0]     r_min;
  logic [CNT_W-1:0] r_max_idx;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  logic             w_rst_n;
  logic             w_beat;
  logic             w_max_ge;
  logic             w_data_ge_min;

  // Reset asserts asynchronously but releases two clocks later, in step with i_clk.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_beat = i_valid & r_ready;

  sm_ge #(.N(N)) u_ge_max (
    .i_a  (r_max),
    .i_b  (i_data),
    .o_ge (w_max_ge)
  );

  sm_ge #(.N(N)) u_ge_min (
    .i_a  (i_data),
    .i_b  (r_min),
    .o_ge (w_data_ge_min)
  );

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= IDLE;
      r_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_max     <= '0;
      r_min     <= '0;
      r_max_idx <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_beat) begin
            r_max     <= i_data;
            r_min     <= i_data;
            r_max_idx <= '0;
            r_count   <= {{(CNT_W-1){1'b0}}, 1'b1};
            r_ovf     <= 1'b0;
            if (i_last) begin
              r_state <= DONE;
              r_ready <= 1'b0;
              r_valid <= 1'b1;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_beat) begin
            if (!w_max_ge) begin
              r_max     <= i_data;
              r_max_idx <= r_count;
            end
            if (!w_data_ge_min) r_min <= i_data;
            if (r_count == CNT_SAT) r_ovf   <= 1'b1;
            else                    r_count <= r_count + 1'b1;
            if (i_last) begin
              r_state <= DONE;
              r_ready <= 1'b0;
              r_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (i_ready) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready   = r_ready;
  assign o_valid   = r_valid;
  assign o_max     = r_max;
  assign o_min     = r_min;
  assign o_max_idx = r_max_idx;
  assign o_count   = r_count;
  assign o_ovf     = r_ovf;
endmodule
